// File: rtl/scheduler_prog_loader_pkg.sv
// Shared constants, state encoding and address helpers for the scheduler
// program image loader.
package scheduler_prog_loader_pkg;

   localparam int C_IMG_BYTES = 2112;
   localparam int C_IMG_BITS  = C_IMG_BYTES * 8;
   localparam int C_IDX_W     = 12;

   // Region base addresses within the image (byte index)
   localparam int C_BASE_INST = 0;
   localparam int C_BASE_RSV0 = 1008;
   localparam int C_BASE_DAY  = 1024;
   localparam int C_BASE_WEEK = 1536;
   localparam int C_BASE_PAT  = 2048;
   localparam int C_BASE_RSV1 = 2100;

   localparam logic [7:0] C_SYNC = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR_H,
      ST_ADDR_L,
      ST_LEN_H,
      ST_LEN_L,
      ST_DATA,
      ST_CSUM
   } prog_state_t;

   // Reserved bytes are counted and summed but never stored, so the
   // consumer always sees zeros there.
   function automatic logic is_reserved(input logic [C_IDX_W-1:0] idx);
      return ((idx >= C_IDX_W'(C_BASE_RSV0)) && (idx < C_IDX_W'(C_BASE_DAY))) ||
             (idx >= C_IDX_W'(C_BASE_RSV1));
   endfunction

endpackage

// File: rtl/scheduler_prog_loader_if.sv
// Byte stream handshake from the host link / UI bridge into the loader.
interface scheduler_prog_loader_if;

   logic       valid;
   logic [7:0] data;
   logic       ready;

   modport master (output valid, output data, input  ready);
   modport slave  (input  valid, input  data, output ready);

endinterface

// File: rtl/scheduler_prog_loader_frame_timer.sv
// Inter-byte watchdog for the frame loader. Counts down while a frame is in
// progress with no byte arriving; expires after g_clk_freq*g_timeout_s idle
// cycles. Clearing parks the counter at zero; the first idle cycle loads it.
module prog_frame_timer #(
   parameter int g_clk_freq  = 20000,
   parameter int g_timeout_s = 2
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_clear,
   input  logic i_run,
   output logic o_expired
);

   localparam int C_LIMIT = g_clk_freq * g_timeout_s;
   localparam int C_CNT_W = $clog2(C_LIMIT + 1);
   localparam logic [C_CNT_W-1:0] C_RELOAD = C_CNT_W'(C_LIMIT - 1);
   localparam logic [C_CNT_W-1:0] C_TC     = C_CNT_W'(1);

   logic [C_CNT_W-1:0] cnt;

   // Down-counter: load on first idle cycle, decrement toward terminal count
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         cnt <= '0;
      end else if (i_clear) begin
         cnt <= '0;
      end else if (i_run) begin
         if (cnt == '0) begin
            cnt <= C_RELOAD;
         end else begin
            cnt <= cnt - C_CNT_W'(1);
         end
      end
   end

   assign o_expired = i_run && ((C_LIMIT == 1) || (cnt == C_TC));

endmodule

// File: rtl/scheduler_prog_loader.sv
// Writer side of the scheduler program image. Parses framed bytes
//   A5, ADDR_H, ADDR_L, LEN_H, LEN_L, LEN data bytes, CSUM
// and writes the data into the 2112-byte image; the image is flagged valid
// only after the mod-256 sum of every byte after sync (including CSUM) is 0.
//
//   state     | meaning
//   ----------+--------------------------------------------------
//   ST_IDLE   | hunting for sync byte 0xA5, other bytes dropped
//   ST_ADDR_H | expecting start address high byte
//   ST_ADDR_L | expecting start address low byte
//   ST_LEN_H  | expecting length high byte
//   ST_LEN_L  | expecting length low byte, range check on exit
//   ST_DATA   | writing LEN bytes from ADDR upward
//   ST_CSUM   | expecting checksum byte, commit or flag error
module scheduler_prog_loader
   import scheduler_prog_loader_pkg::*;
#(
   parameter int g_clk_freq  = 20000,
   parameter int g_timeout_s = 2
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_reprogram_n,
   scheduler_prog_loader_if.slave rx,
   output logic [C_IMG_BITS-1:0] o_slv_prog,
   output logic                  o_prog_valid,
   output logic                  o_prog_busy,
   output logic                  o_prog_done,
   output logic                  o_prog_error
);

   prog_state_t        state;
   prog_state_t        state_nxt;

   logic               take;
   logic               busy;
   logic               abort;
   logic               expired;
   logic               tmr_clear;
   logic               tmr_run;

   logic [15:0]        addr_q;
   logic [15:0]        len_q;
   logic [15:0]        left_q;
   logic [C_IDX_W-1:0] widx_q;
   logic [7:0]         sum_q;
   logic               valid_q;
   logic               done_q;
   logic               err_q;

   logic [7:0]         sum_add;
   logic [15:0]        len_full;
   logic [16:0]        end_addr;
   logic               len_bad;

   logic               err_set;
   logic               err_clr;
   logic               sum_clr;
   logic               valid_set;
   logic               valid_clr;
   logic               done_set;
   logic               data_start;
   logic               wr_en;

   assign rx.ready = ~i_reprogram_n;
   assign take     = rx.valid & ~i_reprogram_n;
   assign busy     = (state != ST_IDLE);
   // Lock-out while a frame is open kills it immediately; the flag is shown
   // combinationally so the host sees the abort in the same cycle.
   assign abort    = busy & i_reprogram_n;

   assign sum_add  = sum_q + rx.data;
   assign len_full = {len_q[15:8], rx.data};
   assign end_addr = {1'b0, addr_q} + {1'b0, len_full};
   assign len_bad  = (len_full == 16'd0) || (end_addr > 17'(C_IMG_BYTES));

   assign tmr_clear = ~busy | take;
   assign tmr_run   = busy & ~take;

   prog_frame_timer #(
      .g_clk_freq  (g_clk_freq),
      .g_timeout_s (g_timeout_s)
   ) u_timer (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_clear   (tmr_clear),
      .i_run     (tmr_run),
      .o_expired (expired)
   );

   // State register
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and control strobes; one state advance per accepted byte
   always_comb begin
      state_nxt  = state;
      err_set    = 1'b0;
      err_clr    = 1'b0;
      sum_clr    = 1'b0;
      valid_set  = 1'b0;
      valid_clr  = 1'b0;
      done_set   = 1'b0;
      data_start = 1'b0;
      wr_en      = 1'b0;
      if (abort || expired) begin
         state_nxt = ST_IDLE;
         err_set   = 1'b1;
      end else if (take) begin
         case (state)
            ST_IDLE: begin
               if (rx.data == C_SYNC) begin
                  state_nxt = ST_ADDR_H;
                  err_clr   = 1'b1;
                  sum_clr   = 1'b1;
               end
            end
            ST_ADDR_H: state_nxt = ST_ADDR_L;
            ST_ADDR_L: state_nxt = ST_LEN_H;
            ST_LEN_H:  state_nxt = ST_LEN_L;
            ST_LEN_L: begin
               if (len_bad) begin
                  state_nxt = ST_IDLE;
                  err_set   = 1'b1;
               end else begin
                  state_nxt  = ST_DATA;
                  valid_clr  = 1'b1;
                  data_start = 1'b1;
               end
            end
            ST_DATA: begin
               wr_en = 1'b1;
               if (left_q == 16'd1) begin
                  state_nxt = ST_CSUM;
               end
            end
            ST_CSUM: begin
               state_nxt = ST_IDLE;
               if (sum_add == 8'h00) begin
                  valid_set = 1'b1;
                  done_set  = 1'b1;
               end else begin
                  err_set = 1'b1;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // Frame header capture, running checksum, write pointer and status flags
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         addr_q  <= '0;
         len_q   <= '0;
         left_q  <= '0;
         widx_q  <= '0;
         sum_q   <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= done_set;
         if (err_set) begin
            err_q <= 1'b1;
         end else if (err_clr) begin
            err_q <= 1'b0;
         end
         if (valid_set) begin
            valid_q <= 1'b1;
         end else if (valid_clr) begin
            valid_q <= 1'b0;
         end
         if (take) begin
            sum_q <= sum_clr ? 8'h00 : sum_add;
            case (state)
               ST_ADDR_H: addr_q[15:8] <= rx.data;
               ST_ADDR_L: addr_q[7:0]  <= rx.data;
               ST_LEN_H:  len_q[15:8]  <= rx.data;
               ST_LEN_L:  len_q[7:0]   <= rx.data;
               default: ;
            endcase
         end
         if (data_start) begin
            // Range check has passed, so the address fits the byte index
            widx_q <= addr_q[C_IDX_W-1:0];
            left_q <= len_full;
         end else if (wr_en) begin
            widx_q <= widx_q + C_IDX_W'(1);
            left_q <= left_q - 16'd1;
         end
      end
   end

   // Image store: byte-indexed write, reserved bytes are never touched
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_slv_prog <= '0;
      end else if (wr_en && !is_reserved(widx_q)) begin
         o_slv_prog[{widx_q, 3'b000} +: 8] <= rx.data;
      end
   end

   assign o_prog_valid = valid_q;
   assign o_prog_busy  = busy;
   assign o_prog_done  = done_q;
   assign o_prog_error = err_q | abort;

endmodule

// File: tb/tb_scheduler_prog_loader.sv
// Bench for scheduler_prog_loader: a vector table of frames with hand-derived
// flag outcomes, randomized frames against a byte-array image model, and
// directed sequences for timeout, lock-out abort, resync and async reset.
module tb_scheduler_prog_loader;
   import scheduler_prog_loader_pkg::*;

   localparam int P_LIMIT = 8;   // 4 ticks/s * 2 s

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  reprog_n = 1'b0;
   logic [C_IMG_BITS-1:0] slv_prog;
   logic                  prog_valid;
   logic                  prog_busy;
   logic                  prog_done;
   logic                  prog_error;

   scheduler_prog_loader_if rx_if();

   scheduler_prog_loader #(
      .g_clk_freq  (4),
      .g_timeout_s (2)
   ) dut (
      .i_clk         (clk),
      .i_reset_n     (rst_n),
      .i_reprogram_n (reprog_n),
      .rx            (rx_if),
      .o_slv_prog    (slv_prog),
      .o_prog_valid  (prog_valid),
      .o_prog_busy   (prog_busy),
      .o_prog_done   (prog_done),
      .o_prog_error  (prog_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] addr;
      logic [15:0] len;
      int          mode;     // 0 inst1 pattern, 1 all FF, 2 random, 3 all A5
      logic [7:0]  delta;    // added to the correct checksum
      logic        e_done;
      logic        e_valid;
      logic        e_error;
   } vec_t;

   int         checks = 0;
   int         failures = 0;
   int         done_pulses = 0;
   int         exp_done_pulses = 0;
   int         both_hi = 0;
   int         gap_max = 0;
   logic [7:0] mdl_img [C_IMG_BYTES];
   logic       mdl_valid = 1'b0;
   logic       mdl_error = 1'b0;
   logic [7:0] fdata [$];
   logic [7:0] inst1 [16] = '{8'h80, 8'h08, 8'h14, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00,
                              8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hF0, 8'h00, 8'h00};
   vec_t       tbl [12];

   always @(negedge clk) begin
      if (prog_done) done_pulses++;
      if (prog_done && prog_error) both_hi++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_image(input string name);
      int bad;
      bad = -1;
      checks++;
      for (int b = 0; b < C_IMG_BYTES; b++) begin
         if (bad < 0 && slv_prog[8*b +: 8] !== mdl_img[b]) bad = b;
      end
      if (bad >= 0) begin
         failures++;
         $display("FAIL %s: image byte %0d got %0h expected %0h",
                  name, bad, slv_prog[8*bad +: 8], mdl_img[bad]);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] d);
      rx_if.valid = 1'b1;
      rx_if.data  = d;
      @(posedge clk);
      #1;
      rx_if.valid = 1'b0;
   endtask

   task automatic fill(input int mode, input int len);
      fdata.delete();
      for (int i = 0; i < len; i++) begin
         case (mode)
            0:       fdata.push_back(inst1[i % 16]);
            1:       fdata.push_back(8'hFF);
            3:       fdata.push_back(8'hA5);
            default: fdata.push_back(8'($urandom_range(0, 255)));
         endcase
      end
   endtask

   function automatic bit mdl_rsv(input int a);
      return (a >= C_BASE_RSV0 && a < C_BASE_DAY) || (a >= C_BASE_RSV1 && a < C_IMG_BYTES);
   endfunction

   // Frame-level effect: reject on bad range, else store data and judge sum
   task automatic model_frame(input logic [15:0] addr, input logic [15:0] len,
                              input logic [7:0] csum, output logic e_done);
      int total;
      e_done = 1'b0;
      if (len == 0 || int'(addr) + int'(len) > C_IMG_BYTES) begin
         mdl_error = 1'b1;
         return;
      end
      total = int'(addr[15:8]) + int'(addr[7:0]) + int'(len[15:8]) + int'(len[7:0]) + int'(csum);
      for (int k = 0; k < int'(len); k++) begin
         total += int'(fdata[k]);
         if (!mdl_rsv(int'(addr) + k)) mdl_img[int'(addr) + k] = fdata[k];
      end
      mdl_valid = ((total % 256) == 0);
      mdl_error = !mdl_valid;
      e_done    = mdl_valid;
      if (e_done) exp_done_pulses++;
   endtask

   task automatic run_frame(input string nm, input logic [15:0] addr, input logic [15:0] len,
                            input int mode, input logic [7:0] delta, output logic got_done);
      logic [7:0] s;
      logic [7:0] csum;
      logic       e_done;
      bit         lenerr;
      int         g;
      fill(mode, int'(len));
      s = addr[15:8] + addr[7:0] + len[15:8] + len[7:0];
      foreach (fdata[k]) s = s + fdata[k];
      csum   = 8'h00 - s + delta;
      lenerr = (len == 0) || (int'(addr) + int'(len) > C_IMG_BYTES);
      got_done = 1'b0;
      send_byte(C_SYNC);
      check({nm, " sync busy"}, prog_busy, 1);
      check({nm, " sync err clear"}, prog_error, 0);
      send_byte(addr[15:8]);
      send_byte(addr[7:0]);
      send_byte(len[15:8]);
      send_byte(len[7:0]);
      if (lenerr) begin
         check({nm, " busy drop"}, prog_busy, 0);
      end else begin
         check({nm, " valid dirty"}, prog_valid, 0);
         foreach (fdata[k]) begin
            g = $urandom_range(0, gap_max);
            if (g > 0) tick(g);
            send_byte(fdata[k]);
         end
         send_byte(csum);
         got_done = prog_done;
         tick(1);
         check({nm, " done width"}, prog_done, 0);
      end
      model_frame(addr, len, csum, e_done);
      check({nm, " done"}, got_done, e_done);
      check({nm, " valid"}, prog_valid, mdl_valid);
      check({nm, " error"}, prog_error, mdl_error);
      check_image({nm, " image"});
   endtask

   initial begin
      logic gd;
      logic [15:0] ra;
      logic [15:0] rl;
      logic [7:0]  rd;

      tbl[0]  = '{16'd16,    16'd16, 0, 8'h00, 1'b1, 1'b1, 1'b0};
      tbl[1]  = '{16'd16,    16'd16, 0, 8'h01, 1'b0, 1'b0, 1'b1};
      tbl[2]  = '{16'd2108,  16'd8,  2, 8'h00, 1'b0, 1'b0, 1'b1};
      tbl[3]  = '{16'd1006,  16'd4,  1, 8'h00, 1'b1, 1'b1, 1'b0};
      tbl[4]  = '{16'd0,     16'd0,  2, 8'h00, 1'b0, 1'b1, 1'b1};
      tbl[5]  = '{16'd2100,  16'd12, 2, 8'h00, 1'b1, 1'b1, 1'b0};
      tbl[6]  = '{16'd2048,  16'd64, 2, 8'h00, 1'b1, 1'b1, 1'b0};
      tbl[7]  = '{16'd2049,  16'd64, 2, 8'h00, 1'b0, 1'b1, 1'b1};
      tbl[8]  = '{16'hFFFF,  16'd2,  2, 8'h00, 1'b0, 1'b1, 1'b1};
      tbl[9]  = '{16'd100,   16'd3,  3, 8'h00, 1'b1, 1'b1, 1'b0};
      tbl[10] = '{16'd1016,  16'd16, 0, 8'h00, 1'b1, 1'b1, 1'b0};
      tbl[11] = '{16'd500,   16'd5,  2, 8'h80, 1'b0, 1'b0, 1'b1};

      foreach (mdl_img[b]) mdl_img[b] = 8'h00;
      rx_if.valid = 1'b0;
      rx_if.data  = 8'h00;

      // Reset state
      tick(3);
      check("rst busy", prog_busy, 0);
      check("rst valid", prog_valid, 0);
      check("rst error", prog_error, 0);
      check("rst done", prog_done, 0);
      check("rst image", 32'(|slv_prog), 0);
      check("ready open", rx_if.ready, 1);
      reprog_n = 1'b1;
      #1;
      check("ready locked", rx_if.ready, 0);
      reprog_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick(1);

      // Table vectors
      gap_max = 1;
      foreach (tbl[i]) begin
         run_frame($sformatf("vec%0d", i), tbl[i].addr, tbl[i].len, tbl[i].mode, tbl[i].delta, gd);
         check($sformatf("vec%0d tbl done", i), gd, tbl[i].e_done);
         check($sformatf("vec%0d tbl valid", i), prog_valid, tbl[i].e_valid);
         check($sformatf("vec%0d tbl error", i), prog_error, tbl[i].e_error);
      end
      check("inst1 byte16", slv_prog[135:128], 8'h80);
      check("inst1 byte17", slv_prog[143:136], 8'h08);
      check("inst1 byte28", slv_prog[231:224], 8'hFF);
      check("inst1 byte29", slv_prog[239:232], 8'hF0);
      check("rsv byte1008", slv_prog[8*1008 +: 8], 8'h00);
      check("byte1007", slv_prog[8*1007 +: 8], 8'hFF);

      // Inter-byte timeout mid-DATA
      fill(2, 4);
      send_byte(C_SYNC);
      send_byte(8'h00);
      send_byte(8'h40);
      send_byte(8'h00);
      send_byte(8'h04);
      send_byte(fdata[0]);
      send_byte(fdata[1]);
      mdl_img[64] = fdata[0];
      mdl_img[65] = fdata[1];
      mdl_valid = 1'b0;
      tick(P_LIMIT - 2);
      check("stall busy early", prog_busy, 1);
      check("stall error early", prog_error, 0);
      check("stall valid dirty", prog_valid, 0);
      tick(4);
      check("stall busy late", prog_busy, 0);
      check("stall error late", prog_error, 1);
      mdl_error = 1'b1;
      check_image("stall image");

      // Bytes dropped in IDLE until sync, then a good frame clears the error
      send_byte(8'h03);
      send_byte(8'h00);
      check("junk busy", prog_busy, 0);
      check("junk error", prog_error, 1);
      run_frame("resync", 16'd1536, 16'd10, 2, 8'h00, gd);

      // Lock-out abort mid-DATA
      fill(2, 4);
      send_byte(C_SYNC);
      send_byte(8'h00);
      send_byte(8'h50);
      send_byte(8'h00);
      send_byte(8'h04);
      send_byte(fdata[0]);
      mdl_img[80] = fdata[0];
      mdl_valid = 1'b0;
      mdl_error = 1'b1;
      reprog_n = 1'b1;
      #2;
      check("abort error same cycle", prog_error, 1);
      check("abort ready", rx_if.ready, 0);
      tick(1);
      check("abort busy", prog_busy, 0);
      check("abort error sticky", prog_error, 1);
      send_byte(C_SYNC);
      check("locked sync ignored", prog_busy, 0);
      reprog_n = 1'b0;
      tick(1);
      check("abort valid", prog_valid, 0);
      check_image("abort image");

      // Randomized frames against the model
      gap_max = 3;
      run_frame("pre rnd", 16'd2000, 16'd20, 2, 8'h00, gd);
      for (int r = 0; r < 40; r++) begin
         if ($urandom_range(0, 7) == 0) ra = 16'($urandom_range(2060, 2200));
         else                           ra = 16'($urandom_range(0, 2100));
         if ($urandom_range(0, 9) == 0) rl = 16'd0;
         else                           rl = 16'($urandom_range(1, 40));
         if ($urandom_range(0, 4) == 0) rd = 8'($urandom_range(1, 255));
         else                           rd = 8'h00;
         run_frame($sformatf("rnd%0d", r), ra, rl, 2, rd, gd);
      end

      // Async reset mid-DATA
      run_frame("pre rst", 16'd200, 16'd6, 2, 8'h00, gd);
      send_byte(C_SYNC);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h08);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      #3;
      rst_n = 1'b0;
      #1;
      check("async rst image", 32'(|slv_prog), 0);
      check("async rst valid", prog_valid, 0);
      check("async rst busy", prog_busy, 0);
      check("async rst error", prog_error, 0);
      foreach (mdl_img[b]) mdl_img[b] = 8'h00;
      mdl_valid = 1'b0;
      mdl_error = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick(1);
      run_frame("post rst", 16'd1024, 16'd12, 2, 8'h00, gd);

      tick(2);
      check("done pulse count", done_pulses, exp_done_pulses);
      check("done with error", both_hi, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
